cube_scanner: RTL
=================

CUBE_SCANNER -- requirements
Module: cube_scanner

Interface
REQ-001 Parameter N, default 8: cube edge; layers, rows per layer and LEDs per row.
REQ-002 Parameter BRIGHT_W, default 4: brightness width; levels 0..2^BRIGHT_W-1.
REQ-003 Parameter DEAD, default 4: anti-ghost blank cycles at the start of each slot.
REQ-004 Parameter STEP, default 8: on-cycles per brightness level.
REQ-005 Derived constants (not ports) SHALL be SLOT = DEAD + STEP*(2^BRIGHT_W-1), 124 with defaults, and FRAME = N*N*SLOT.
REQ-006 clk  in  1  system clock; one clock; all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous and active-high.
REQ-008 frame_cube_flat  in  N*N*N  frame data; bit index = l*N*N + r*N + c.
REQ-009 frame_valid  in  1  one-cycle strobe; frame_cube_flat is valid this cycle.
REQ-010 brightness  in  BRIGHT_W  global brightness level.
REQ-011 blank  in  1  forces all drive outputs off.
REQ-012 high_csn  out  N  layer select, active low, one-hot-low.
REQ-013 row  out  N  LED data for the selected row, 1 = on.
REQ-014 row_cs  out  N  row select, active high, one-hot.
REQ-015 frame_swap  out  1  one-cycle pulse when a new frame becomes active.
REQ-016 frames_dropped  out  16  saturating count of overwritten pending frames.

Function
REQ-017 Scan state SHALL consist of layer l (0..N-1), row r (0..N-1) and slot counter cnt (0..SLOT-1); cnt SHALL increment every cycle.
REQ-018 On cnt wrap, r SHALL increment; on r wrap, l SHALL increment; on l wrap, the scan restarts at (0,0,0). Order: row inner, layer outer.
REQ-019 Data SHALL be double-buffered: a shadow register and an active register, each N*N*N bits.
REQ-020 frame_valid SHALL write frame_cube_flat into shadow and set pending.
REQ-021 If frame_valid arrives while pending=1 (not on the swap cycle), shadow SHALL be overwritten (latest frame wins) and frames_dropped SHALL increment, saturating at 16'hFFFF.
REQ-022 Swap cycle is defined as l=N-1, r=N-1, cnt=SLOT-1. If pending=1 on the swap cycle, active SHALL load shadow, pending SHALL clear, and frame_swap SHALL be 1 on the following cycle.
REQ-023 When frame_valid coincides with a swap cycle, active SHALL take the old shadow contents, shadow SHALL take the new data, pending SHALL stay 1, and no drop SHALL be counted.
REQ-024 brightness SHALL be sampled into an internal register only at cnt=0; mid-slot changes SHALL have no effect until the next slot.
REQ-025 A slot SHALL be enabled when blank=0 and DEAD <= cnt < DEAD + STEP*b, where b is the sampled brightness. With b=0 the slot is never enabled; with b=max it is on for SLOT-DEAD cycles.
REQ-026 When enabled: high_csn = ~(1<<l), row_cs = 1<<r, row[c] = active[l*N*N + r*N + c].
REQ-027 When not enabled, outputs SHALL be blanked: high_csn all ones, row_cs all zeros, row all zeros.
REQ-028 All drive outputs SHALL be registered, with one cycle of latency from scan state: the output at cycle t reflects (l,r,cnt,blank) at cycle t-1.
REQ-029 The scan SHALL continue independently of blank and brightness; frame swaps and drop counting SHALL proceed while blanked.
REQ-030 At no time SHALL more than one bit of row_cs be high, or more than one bit of high_csn be low.

Reset
REQ-031 rst=1 SHALL set l, r and cnt to 0, clear active, shadow and pending, set frames_dropped=0 and frame_swap=0, and blank all drive outputs on the next edge.
REQ-032 rst asserted mid-scan or mid-frame SHALL discard a pending frame, with no frame_swap pulse.
REQ-033 On the first cycle after rst deasserts, cnt SHALL be 0 at l=0, r=0.

Verification (N=8, defaults)
REQ-034 Load all-ones frame, brightness=15 -> frame_swap after the current scan; each slot shows row=8'hFF for 120 cycles after 4 blank cycles; no ghost overlap between slots.
REQ-035 Single bit 171 (l=2, r=5, c=3) -> only slot (2,5) drives row=8'h08, row_cs=8'h20, high_csn=8'hFB; all other slots show row=0.
REQ-036 brightness=0 or blank=1 -> outputs stay blanked for a full FRAME (7936 cycles); a pending frame still swaps at the frame boundary.
REQ-037 Two frame_valid strobes within one scan -> frames_dropped=1, and the second frame is displayed after the swap; frame_valid on the swap cycle -> old shadow displayed, pending stays 1, frames_dropped unchanged.
REQ-038 brightness changed at cnt=50 from 15 to 1 -> the current slot stays fully on; the next slot is on only for cnt 4..11.
REQ-039 rst pulsed at l=3, r=2, cnt=70 with a frame pending -> outputs blank next cycle, counters restart at 0, active is all zeros, no frame_swap pulse.

Source files
------------

// File: rtl/cube_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : cube_scanner
//  Description : Row-multiplexed scan driver for an N x N x N LED cube.
//                Walks every (layer,row) slot in turn, row inner and layer
//                outer. Each slot opens with a dead band that suppresses
//                ghosting, followed by an on window whose length scales
//                with the brightness level. Frame data is double-buffered
//                and a pending frame is promoted only at the last cycle of
//                a full scan, so a frame is never shown half-updated.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             system clock, all logic on the rising edge
//    rst             synchronous active-high reset
//    frame_cube_flat N*N*N frame bits, index = l*N*N + r*N + c
//    frame_valid     one-cycle strobe qualifying frame_cube_flat
//    brightness      global brightness level, taken at the start of a slot
//    blank           forces all drive outputs off
//    high_csn        layer select, active low, one-hot-low
//    row             LED data for the selected row, 1 = on
//    row_cs          row select, active high, one-hot
//    frame_swap      one-cycle pulse when a new frame becomes active
//    frames_dropped  saturating count of overwritten pending frames
// ============================================================================
module cube_scanner #(
    parameter int N        = 8,
    parameter int BRIGHT_W = 4,
    parameter int DEAD     = 4,
    parameter int STEP     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*N*N-1:0]      frame_cube_flat,
    input  logic                  frame_valid,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  blank,
    output logic [N-1:0]          high_csn,
    output logic [N-1:0]          row,
    output logic [N-1:0]          row_cs,
    output logic                  frame_swap,
    output logic [15:0]           frames_dropped
);

    // ------------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------------
    localparam int LEVELS = (1 << BRIGHT_W) - 1;
    localparam int SLOT   = DEAD + STEP * LEVELS;
    localparam int FRAME  = N * N * SLOT;
    localparam int IDX_W  = (N > 1)    ? $clog2(N)     : 1;
    localparam int SEL_W  = (N > 1)    ? $clog2(N * N) : 1;
    localparam int CNT_W  = (SLOT > 1) ? $clog2(SLOT)  : 1;

    // A frame shorter than one cycle per slot means the parameter set
    // describes no usable scan; nothing is built either way, the branch only
    // documents the relationship between slot and frame length.
    if (FRAME < N * N) begin : g_degenerate_frame
    end

    // ------------------------------------------------------------------------
    // Scan position: cnt inner, row middle, layer outer
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] r_layer;
    logic [IDX_W-1:0] r_row;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_last;
    logic             w_row_last;
    logic             w_layer_last;
    logic             w_swap;

    assign w_cnt_last   = (r_cnt   == CNT_W'(SLOT - 1));
    assign w_row_last   = (r_row   == IDX_W'(N - 1));
    assign w_layer_last = (r_layer == IDX_W'(N - 1));

    // Last cycle of the last slot of the frame: the only point where the
    // displayed frame may change.
    assign w_swap = w_cnt_last && w_row_last && w_layer_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer <= '0;
            r_row   <= '0;
            r_cnt   <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_row_last) begin
                r_row   <= '0;
                r_layer <= w_layer_last ? '0 : r_layer + 1'b1;
            end else begin
                r_row <= r_row + 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Double-buffered frame store
    // ------------------------------------------------------------------------
    // Packed as N*N rows of N bits so that element (l*N + r) holds exactly
    // bits [l*N*N + r*N +: N] of the flat input vector.
    logic [N*N-1:0][N-1:0] r_shadow;
    logic [N*N-1:0][N-1:0] r_active;
    logic                  r_pending;
    logic                  r_frame_swap;
    logic [15:0]           r_dropped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_frame_swap <= 1'b0;
            r_dropped    <= '0;
        end else begin
            // Latest frame always wins the shadow slot.
            if (frame_valid) begin
                r_shadow <= frame_cube_flat;
            end

            // Active takes the shadow as it was before this edge, so a strobe
            // landing on the swap cycle promotes the older frame and leaves
            // the new one waiting for the next boundary.
            if (w_swap && r_pending) begin
                r_active <= r_shadow;
            end

            if (frame_valid) begin
                r_pending <= 1'b1;
            end else if (w_swap) begin
                r_pending <= 1'b0;
            end

            r_frame_swap <= w_swap && r_pending;

            // On the swap cycle the pending frame is consumed, not lost.
            if (frame_valid && r_pending && !w_swap && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Brightness and slot enable
    // ------------------------------------------------------------------------
    logic [BRIGHT_W-1:0] r_bright;
    logic [BRIGHT_W-1:0] w_bright;
    logic [31:0]         w_cnt_ext;
    logic [31:0]         w_on_end;
    logic                w_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright <= '0;
        end else if (r_cnt == '0) begin
            r_bright <= brightness;
        end
    end

    // At cnt=0 the register is only now being loaded, so the live input is
    // the value that governs this slot. This keeps DEAD=0 configurations
    // correct without a cycle of lag.
    assign w_bright = (r_cnt == '0) ? brightness : r_bright;

    assign w_cnt_ext = 32'(r_cnt);
    assign w_on_end  = 32'(DEAD) + 32'(STEP) * 32'(w_bright);
    assign w_enable  = !blank && (w_cnt_ext >= 32'(DEAD)) && (w_cnt_ext < w_on_end);

    // ------------------------------------------------------------------------
    // Registered drive outputs
    // ------------------------------------------------------------------------
    logic [SEL_W-1:0] w_sel;
    logic [N-1:0]     r_high_csn;
    logic [N-1:0]     r_row_cs;
    logic [N-1:0]     r_row_data;

    assign w_sel = SEL_W'(r_layer) * SEL_W'(N) + SEL_W'(r_row);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_high_csn <= '1;
            r_row_cs   <= '0;
            r_row_data <= '0;
        end else if (w_enable) begin
            r_high_csn <= ~(N'(1) << r_layer);
            r_row_cs   <= N'(1) << r_row;
            r_row_data <= r_active[w_sel];
        end else begin
            r_high_csn <= '1;
            r_row_cs   <= '0;
            r_row_data <= '0;
        end
    end

    assign high_csn       = r_high_csn;
    assign row_cs         = r_row_cs;
    assign row            = r_row_data;
    assign frame_swap     = r_frame_swap;
    assign frames_dropped = r_dropped;

endmodule
`default_nettype wire
